// File: rtl/probatina_example_rd_burst_gen_if.sv
// AXI4 read-address channel plus the R-channel handshake bits watched by the burst generator.
interface probatina_example_rd_burst_gen_if #(
  parameter int C_ADDR_WIDTH = 64
);
  logic                    arvalid;
  logic                    arready;
  logic [C_ADDR_WIDTH-1:0] araddr;
  logic [7:0]              arlen;
  logic                    rvalid;
  logic                    rready;
  logic                    rlast;

  modport master (
    output arvalid, araddr, arlen,
    input  arready, rvalid, rready, rlast
  );

  modport slave (
    input  arvalid, araddr, arlen,
    output arready, rvalid, rready, rlast
  );
endinterface

// File: rtl/probatina_example_rd_burst_gen.sv
// Splits one kernel read request into fixed-size AXI4 AR bursts, throttled by an outstanding-burst limit.
// Optional macro PROBATINA_RD_STALL_CNT_EN adds the stall_cycles counter output.
module probatina_example_rd_burst_gen #(
  parameter int C_ADDR_WIDTH      = 64,
  parameter int C_DATA_WIDTH      = 512,
  parameter int C_XFER_SIZE_WIDTH = 32,
  parameter int C_BURST_LEN       = 64,
  parameter int C_MAX_OUTSTANDING = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   ctrl_start,
  input  logic [C_ADDR_WIDTH-1:0]                ctrl_addr_offset,
  input  logic [C_XFER_SIZE_WIDTH-1:0]           ctrl_xfer_size_in_beats,
  output logic                                   ctrl_busy,
  output logic                                   ctrl_done,
  output logic [$clog2(C_MAX_OUTSTANDING+1)-1:0] outstanding,
`ifdef PROBATINA_RD_STALL_CNT_EN
  output logic [31:0]                            stall_cycles,
`endif
  probatina_example_rd_burst_gen_if.master       m_axi
);

  localparam int OUT_W   = $clog2(C_MAX_OUTSTANDING + 1);
  localparam int XW      = C_XFER_SIZE_WIDTH;
  localparam int LOG2_BL = $clog2(C_BURST_LEN);
  localparam logic [OUT_W-1:0]        MAX_OUT     = OUT_W'(C_MAX_OUTSTANDING);
  localparam logic [XW-1:0]           REM_MASK    = XW'(C_BURST_LEN - 1);
  localparam logic [8:0]              FULL_LEN    = 9'(C_BURST_LEN);
  localparam logic [C_ADDR_WIDTH-1:0] BURST_BYTES = C_ADDR_WIDTH'(C_BURST_LEN * (C_DATA_WIDTH / 8));

  typedef enum logic [2:0] {IDLE, SETUP, ISSUE, DRAIN, DONE} state_t;

  state_t                  state;
  logic [C_ADDR_WIDTH-1:0] base_q;
  logic [XW-1:0]           size_q;
  logic [XW-1:0]           bursts_left;
  logic [8:0]              last_len_q;

  logic                    ar_hs;
  logic                    r_cpl;
  logic [OUT_W-1:0]        outstanding_nxt;
  logic                    arvalid_nxt;
  logic [XW-1:0]           size_rem;
  logic [XW-1:0]           num_bursts;
  logic [8:0]              last_len;

  assign ar_hs = m_axi.arvalid & m_axi.arready;
  // A last beat with nothing outstanding is a protocol error and is dropped.
  assign r_cpl = m_axi.rvalid & m_axi.rready & m_axi.rlast & (outstanding != '0);

  always_comb begin
    // NOTE: default assignment first so every path drives the signal and no latch is inferred.
    outstanding_nxt = outstanding;
    if (ar_hs && !r_cpl)
      outstanding_nxt = outstanding + 1'b1;
    else if (!ar_hs && r_cpl)
      outstanding_nxt = outstanding - 1'b1;
  end

  // Issue decisions look at next-cycle occupancy so a freed slot is reused immediately.
  assign arvalid_nxt = (outstanding_nxt < MAX_OUT);
  assign size_rem    = size_q & REM_MASK;
  assign num_bursts  = (size_q >> LOG2_BL) + XW'(size_rem != '0);
  assign last_len    = (size_rem == '0) ? FULL_LEN : 9'(size_rem);

  function automatic logic [7:0] burst_arlen(input logic [XW-1:0] left, input logic [8:0] len_last);
    return (left == XW'(1)) ? 8'(len_last - 9'd1) : 8'(C_BURST_LEN - 1);
  endfunction

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      state         <= IDLE;
      ctrl_busy     <= 1'b0;
      ctrl_done     <= 1'b0;
      m_axi.arvalid <= 1'b0;
      m_axi.araddr  <= '0;
      m_axi.arlen   <= '0;
      outstanding   <= '0;
      base_q        <= '0;
      size_q        <= '0;
      bursts_left   <= '0;
      last_len_q    <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      case (state)
        IDLE: begin
          if (ctrl_start) begin
            base_q    <= ctrl_addr_offset;
            size_q    <= ctrl_xfer_size_in_beats;
            ctrl_busy <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          bursts_left <= num_bursts;
          last_len_q  <= last_len;
          if (size_q == '0) begin
            ctrl_busy <= 1'b0;
            ctrl_done <= 1'b1;
            state     <= DONE;
          end else begin
            m_axi.araddr  <= base_q;
            m_axi.arlen   <= burst_arlen(num_bursts, last_len);
            m_axi.arvalid <= arvalid_nxt;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (ar_hs) begin
            bursts_left  <= bursts_left - 1'b1;
            m_axi.araddr <= m_axi.araddr + BURST_BYTES;
            if (bursts_left == XW'(1)) begin
              m_axi.arvalid <= 1'b0;
              state         <= DRAIN;
            end else begin
              m_axi.arlen   <= burst_arlen(bursts_left - 1'b1, last_len_q);
              m_axi.arvalid <= arvalid_nxt;
            end
          end else if (!m_axi.arvalid) begin
            m_axi.arvalid <= arvalid_nxt;
          end
        end
        DRAIN: begin
          if (outstanding == '0) begin
            ctrl_busy <= 1'b0;
            ctrl_done <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          ctrl_done <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PROBATINA_RD_STALL_CNT_EN
  // Counts AR backpressure cycles plus issue cycles held off by the outstanding limit.
  always_ff @(posedge clk) begin
    if (rst)
      stall_cycles <= '0;
    else if (state == IDLE && ctrl_start)
      stall_cycles <= '0;
    else if (stall_cycles != '1 &&
             ((m_axi.arvalid && !m_axi.arready) ||
              (state == ISSUE && !m_axi.arvalid && outstanding >= MAX_OUT)))
      stall_cycles <= stall_cycles + 1'b1;
  end
`endif

endmodule
